fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Y86-64 pipeline Fetch stage: the producer side of the F-to-D interface. It drives the f_* bundle that the Decode pipeline register latches.
- Holds the F pipeline register (predicted PC) and selects the fetch PC from the prediction, a branch-mispredict redirect from M, or a ret redirect from W.
- Splits the 10-byte instruction window into fields, computes status and the next predicted PC.
- Locks fetch after HLT, ADR or INS until a redirect arrives.

Parameters:
- IMEM_ADDR_W, 10: instruction memory byte-address width; memory size is 2^IMEM_ADDR_W bytes.
- PC_RESET, 64'h0: value loaded into F_predPC on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- F_stall  in  1  hold F register state (from pipeline control).
- M_icode  in  4  icode in the Memory stage.
- M_Cnd  in  1  branch condition in the Memory stage.
- M_valA  in  64  fall-through PC of the jXX in M.
- W_icode  in  4  icode in the Write-back stage.
- W_valM  in  64  return address popped by ret.
- imem_addr  out  IMEM_ADDR_W  byte address of the window, equal to f_pc[IMEM_ADDR_W-1:0].
- imem_rdata  in  80  bytes f_pc..f_pc+9, little-endian; byte 0 in bits [7:0]; combinational read.
- f_pc  out  64  selected fetch PC.
- f_stat  out  4  status.
- f_icode, f_ifun  out  4 each  instruction fields.
- f_rA, f_rB  out  4 each  register fields; 4'hF when absent.
- f_valC  out  64  constant word.
- f_valP  out  64  f_pc + instruction length.
- F_predPC  out  64  F register.
- f_locked  out  1  fetch lock state.
- f_count  out  32  number of AOK instructions issued.

Behaviour:
- Reset, async on rst_n low: F_predPC=PC_RESET, f_locked=0, f_count=0. The combinational outputs follow from these values.
- Redirects:
  - mispredict = (M_icode==JXX && !M_Cnd).
  - ret_redir = (W_icode==RET).
- PC select, priority order: mispredict gives M_valA; else ret_redir gives W_valM; else F_predPC.
- Fields: byte0 = {icode, ifun}. When a register byte is present, byte1 = {rA, rB}.
- Lengths:
  - 1 byte: HALT, NOP, RET.
  - 2 bytes: RRMOVQ/CMOVXX, OPQ, PUSHQ, POPQ.
  - 9 bytes: JXX, CALL; valC is bytes 1..8.
  - 10 bytes: IRMOVQ, RMMOVQ, MRMOVQ; valC is bytes 2..9.
  - For instructions without a register byte, rA=rB=F. For instructions without a constant, valC=0.
- Validity:
  - icode>4'hB is invalid.
  - OPQ ifun>3 is invalid.
  - JXX or CMOVXX ifun>6 is invalid.
  - Any other icode with ifun!=0 is invalid.
- Status, priority order:
  - ADR if f_pc + length > 2^IMEM_ADDR_W, or f_pc has any bit set at or above IMEM_ADDR_W.
  - Else INS if invalid.
  - Else HLT if icode==HALT.
  - Else AOK.
  - On ADR or INS: f_icode=NOP, f_ifun=0, rA=rB=F, valC=0, valP=f_pc.
- Prediction: next = valC for JXX and CALL; otherwise valP.
- Rising edge with F_stall=1: all state holds.
- Rising edge with F_stall=0:
  - F_predPC <= next, or <= f_pc while locked.
  - f_locked <= 1 if f_stat is HLT, ADR or INS. Otherwise f_locked <= 0 when a redirect is present; otherwise it holds.
  - f_count <= f_count+1 when f_stat==AOK; wraps at 2^32.
- While locked with no redirect:
  - Outputs are a bubble: f_stat=BUB, icode=NOP, ifun=0, rA=rB=F, valC=valP=0.
  - F_predPC holds.
- A redirect while locked: fetch proceeds from the redirect PC in the same cycle. The lock clears on the next unstalled edge, unless the new instruction itself locks.
- Simultaneous redirects: mispredict wins.
- A redirect during F_stall affects the combinational outputs only; no state change.
- Latency: fetch outputs are combinational from state and inputs; no internal pipeline stage.

Decomposition:
- Shared package y86_pkg:
  - icode constants HALT..POPQ (0..B).
  - Status codes SAOK=1, SHLT=2, SADR=3, SINS=4, SBUB=8.
  - Register-none code RNONE=F.
  - Instruction-length function.
- One sub-module, instr_split: combinational field, length, valC and validity extraction from the 80-bit window.

Test Plan:
- Reset, then window {irmovq: 30 F2 + 8-byte constant 64'h10} at PC 0 -> f_stat=1, f_icode=3, f_rB=2, f_valC=64'h10, f_valP=10; F_predPC=10 after the edge; f_count=1.
- call at PC 0x20 with dest 0x100 -> f_valP=0x29; F_predPC=0x100 after the edge.
- jXX in M with M_Cnd=0 and M_valA=0x40, together with W_icode=RET and W_valM=0x80 -> f_pc=0x40 (mispredict priority).
- HLT at PC 5 -> f_stat=2. On the following edges: f_stat=8, F_predPC=6 held, f_locked=1, f_count unchanged. Then W_icode=RET with W_valM=0 -> f_pc=0 and the lock clears on the next edge.
- Byte 8'hC0 -> SINS with f_icode=1; irmovq at PC 2^10-4 -> SADR.
- F_stall=1 for 3 cycles -> F_predPC, f_locked and f_count unchanged. Assert rst_n low mid-stall -> immediate F_predPC=PC_RESET.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register-none code and instruction length.
package y86_pkg;

  typedef logic [3:0] stat_t;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam stat_t SAOK = 4'h1;
  localparam stat_t SHLT = 4'h2;
  localparam stat_t SADR = 4'h3;
  localparam stat_t SINS = 4'h4;
  localparam stat_t SBUB = 4'h8;

  localparam logic [3:0] RNONE = 4'hF;

  // Undefined icodes report length 1 so the address check stays meaningful.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      RRMOVQ, OPQ, PUSHQ, POPQ: instr_len = 4'd2;
      JXX, CALL:                instr_len = 4'd9;
      IRMOVQ, RMMOVQ, MRMOVQ:   instr_len = 4'd10;
      default:                  instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_instr_split.sv
// Combinational decode of the 10-byte fetch window into fields, length, valC and validity.
// Zero latency; no flow control.
module instr_split
  import y86_pkg::*;
(
  input  logic [79:0] i_win,
  output logic [3:0]  o_icode,
  output logic [3:0]  o_ifun,
  output logic [3:0]  o_rA,
  output logic [3:0]  o_rB,
  output logic [63:0] o_valC,
  output logic [3:0]  o_len,
  output logic        o_invalid
);

  logic w_has_regs;

  assign o_icode    = i_win[7:4];
  assign o_ifun     = i_win[3:0];
  assign o_len      = instr_len(o_icode);
  assign w_has_regs = (o_len == 4'd2) || (o_len == 4'd10);
  assign o_rA       = w_has_regs ? i_win[15:12] : RNONE;
  assign o_rB       = w_has_regs ? i_win[11:8]  : RNONE;

  always_comb begin
    o_valC = '0;
    if (o_len == 4'd9)
      o_valC = i_win[71:8];
    else if (o_len == 4'd10)
      o_valC = i_win[79:16];
  end

  always_comb begin
    o_invalid = 1'b0;
    if (o_icode > POPQ) begin
      o_invalid = 1'b1;
    end else begin
      case (o_icode)
        OPQ:         o_invalid = (o_ifun > 4'd3);
        JXX, RRMOVQ: o_invalid = (o_ifun > 4'd6);
        default:     o_invalid = (o_ifun != 4'd0);
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch: PC select, window split, status, prediction; outputs combinational from state.
// F_stall freezes all state; after HLT/ADR/INS fetch emits bubbles until a redirect arrives.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [63:0] PC_RESET    = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   F_stall,
  input  logic [3:0]             M_icode,
  input  logic                   M_Cnd,
  input  logic [63:0]            M_valA,
  input  logic [3:0]             W_icode,
  input  logic [63:0]            W_valM,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [79:0]            imem_rdata,
  output logic [63:0]            f_pc,
  output logic [3:0]             f_stat,
  output logic [3:0]             f_icode,
  output logic [3:0]             f_ifun,
  output logic [3:0]             f_rA,
  output logic [3:0]             f_rB,
  output logic [63:0]            f_valC,
  output logic [63:0]            f_valP,
  output logic [63:0]            F_predPC,
  output logic                   f_locked,
  output logic [31:0]            f_count
);

  localparam logic [IMEM_ADDR_W:0] MEM_BYTES = {1'b1, {IMEM_ADDR_W{1'b0}}};

  logic [63:0]          r_predPC;
  logic                 r_locked;
  logic [31:0]          r_count;

  logic                 w_mispredict;
  logic                 w_ret;
  logic                 w_redirect;
  logic                 w_bubble;
  logic [63:0]          w_pc;
  logic [3:0]           w_icode;
  logic [3:0]           w_ifun;
  logic [3:0]           w_rA;
  logic [3:0]           w_rB;
  logic [63:0]          w_valC;
  logic [3:0]           w_len;
  logic                 w_invalid;
  logic [IMEM_ADDR_W:0] w_end;
  logic                 w_adr;
  logic [63:0]          w_next;

  assign w_mispredict = (M_icode == JXX) && !M_Cnd;
  assign w_ret        = (W_icode == RET);
  assign w_redirect   = w_mispredict || w_ret;
  assign w_pc         = w_mispredict ? M_valA : (w_ret ? W_valM : r_predPC);
  assign w_bubble     = r_locked && !w_redirect;

  assign imem_addr = w_pc[IMEM_ADDR_W-1:0];

  instr_split u_split (
    .i_win     (imem_rdata),
    .o_icode   (w_icode),
    .o_ifun    (w_ifun),
    .o_rA      (w_rA),
    .o_rB      (w_rB),
    .o_valC    (w_valC),
    .o_len     (w_len),
    .o_invalid (w_invalid)
  );

  // One extra bit so an instruction ending exactly at the top of memory is legal.
  assign w_end = {1'b0, w_pc[IMEM_ADDR_W-1:0]} + {{(IMEM_ADDR_W-3){1'b0}}, w_len};
  assign w_adr = (w_pc[63:IMEM_ADDR_W] != '0) || (w_end > MEM_BYTES);

  always_comb begin
    f_pc    = w_pc;
    f_stat  = SAOK;
    f_icode = w_icode;
    f_ifun  = w_ifun;
    f_rA    = w_rA;
    f_rB    = w_rB;
    f_valC  = w_valC;
    f_valP  = w_pc + {60'd0, w_len};
    if (w_bubble) begin
      f_stat  = SBUB;
      f_icode = NOP;
      f_ifun  = 4'h0;
      f_rA    = RNONE;
      f_rB    = RNONE;
      f_valC  = '0;
      f_valP  = '0;
    end else if (w_adr || w_invalid) begin
      f_stat  = w_adr ? SADR : SINS;
      f_icode = NOP;
      f_ifun  = 4'h0;
      f_rA    = RNONE;
      f_rB    = RNONE;
      f_valC  = '0;
      f_valP  = w_pc;
    end else if (w_icode == HALT) begin
      f_stat = SHLT;
    end
  end

  assign w_next = ((f_icode == JXX) || (f_icode == CALL)) ? f_valC : f_valP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_predPC <= PC_RESET;
      r_locked <= 1'b0;
      r_count  <= '0;
    end else if (!F_stall) begin
      r_predPC <= w_bubble ? w_pc : w_next;
      if ((f_stat == SHLT) || (f_stat == SADR) || (f_stat == SINS))
        r_locked <= 1'b1;
      else if (w_redirect)
        r_locked <= 1'b0;
      if (f_stat == SAOK)
        r_count <= r_count + 32'd1;
    end
  end

  assign F_predPC = r_predPC;
  assign f_locked = r_locked;
  assign f_count  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a byte-array instruction memory.
module tb_fetch_stage;
  import y86_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        F_stall;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [9:0]  imem_addr;
  logic [79:0] imem_rdata;
  logic [63:0] f_pc;
  logic [3:0]  f_stat;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [63:0] F_predPC;
  logic        f_locked;
  logic [31:0] f_count;

  logic [7:0]  mem [1024];
  int          n_chk;
  int          n_pass;

  fetch_stage #(.IMEM_ADDR_W(10), .PC_RESET(64'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .F_stall    (F_stall),
    .M_icode    (M_icode),
    .M_Cnd      (M_Cnd),
    .M_valA     (M_valA),
    .W_icode    (W_icode),
    .W_valM     (W_valM),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .f_pc       (f_pc),
    .f_stat     (f_stat),
    .f_icode    (f_icode),
    .f_ifun     (f_ifun),
    .f_rA       (f_rA),
    .f_rB       (f_rB),
    .f_valC     (f_valC),
    .f_valP     (f_valP),
    .F_predPC   (F_predPC),
    .f_locked   (f_locked),
    .f_count    (f_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = '0;
    for (int i = 0; i < 10; i++)
      imem_rdata[8*i +: 8] = mem[imem_addr + 10'(i)];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input logic en, input logic [63:0] pc);
    W_icode = en ? RET : NOP;
    W_valM  = pc;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    F_stall = 1'b0;
    M_icode = NOP;
    M_Cnd = 1'b1;
    M_valA = '0;
    W_icode = NOP;
    W_valM = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
    // irmovq $0x10, %rdx at 0 (byte 5 is 0x00, reused as a HALT target)
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h10;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    // jmp 0x20 at 0xA
    mem[10] = 8'h70; mem[11] = 8'h20;
    for (int i = 12; i < 19; i++) mem[i] = 8'h00;
    // call 0x100 at 0x20
    mem[32] = 8'h80; mem[33] = 8'h00; mem[34] = 8'h01;
    for (int i = 35; i < 41; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'hC0;
    mem[12'h210] = 8'h64;
    mem[10'h3FC] = 8'h30;

    #12;
    chk("rst_predPC", F_predPC, 64'h0);
    chk("rst_locked", {63'd0, f_locked}, 64'd0);
    chk("rst_count", {32'd0, f_count}, 64'd0);
    rst_n = 1'b1;
    #2;
    chk("irmov_stat", {60'd0, f_stat}, 64'd1);
    chk("irmov_icode", {60'd0, f_icode}, 64'd3);
    chk("irmov_rA", {60'd0, f_rA}, 64'hF);
    chk("irmov_rB", {60'd0, f_rB}, 64'd2);
    chk("irmov_valC", f_valC, 64'h10);
    chk("irmov_valP", f_valP, 64'd10);
    tick();
    chk("irmov_predPC", F_predPC, 64'd10);
    chk("irmov_count", {32'd0, f_count}, 64'd1);

    chk("jmp_valC", f_valC, 64'h20);
    tick();
    chk("jmp_predPC", F_predPC, 64'h20);
    chk("call_valP", f_valP, 64'h29);
    chk("call_rA", {60'd0, f_rA}, 64'hF);
    tick();
    chk("call_predPC", F_predPC, 64'h100);
    chk("call_count", {32'd0, f_count}, 64'd3);

    M_icode = JXX; M_Cnd = 1'b0; M_valA = 64'h40;
    set_ret(1'b1, 64'h80);
    chk("mispred_pc", f_pc, 64'h40);
    chk("mispred_valP", f_valP, 64'h41);
    tick();
    chk("mispred_predPC", F_predPC, 64'h41);
    M_icode = NOP; M_Cnd = 1'b1;
    set_ret(1'b1, 64'h80);
    chk("ret_pc", f_pc, 64'h80);

    set_ret(1'b1, 64'd5);
    chk("hlt_stat", {60'd0, f_stat}, 64'd2);
    tick();
    chk("hlt_predPC", F_predPC, 64'd6);
    chk("hlt_locked", {63'd0, f_locked}, 64'd1);
    chk("hlt_count", {32'd0, f_count}, 64'd4);
    set_ret(1'b0, 64'd0);
    chk("bub_stat", {60'd0, f_stat}, 64'd8);
    chk("bub_icode", {60'd0, f_icode}, 64'd1);
    chk("bub_rB", {60'd0, f_rB}, 64'hF);
    chk("bub_valP", f_valP, 64'd0);
    tick();
    chk("bub_predPC", F_predPC, 64'd6);
    chk("bub_count", {32'd0, f_count}, 64'd4);
    chk("bub_locked", {63'd0, f_locked}, 64'd1);

    set_ret(1'b1, 64'd0);
    chk("unlock_pc", f_pc, 64'd0);
    chk("unlock_stat", {60'd0, f_stat}, 64'd1);
    tick();
    chk("unlock_locked", {63'd0, f_locked}, 64'd0);
    chk("unlock_predPC", F_predPC, 64'd10);
    chk("unlock_count", {32'd0, f_count}, 64'd5);

    set_ret(1'b1, 64'h200);
    chk("ins_stat", {60'd0, f_stat}, 64'd4);
    chk("ins_icode", {60'd0, f_icode}, 64'd1);
    chk("ins_valP", f_valP, 64'h200);
    set_ret(1'b1, 64'h210);
    chk("opq_ifun_stat", {60'd0, f_stat}, 64'd4);
    tick();
    chk("ins_locked", {63'd0, f_locked}, 64'd1);
    chk("ins_count", {32'd0, f_count}, 64'd5);

    set_ret(1'b1, 64'h3FC);
    chk("adr_end_stat", {60'd0, f_stat}, 64'd3);
    chk("adr_end_valC", f_valC, 64'd0);
    set_ret(1'b1, 64'h3FF);
    chk("last_byte_stat", {60'd0, f_stat}, 64'd1);
    tick();
    chk("last_byte_predPC", F_predPC, 64'h400);
    chk("last_byte_locked", {63'd0, f_locked}, 64'd0);
    set_ret(1'b0, 64'd0);
    chk("adr_high_stat", {60'd0, f_stat}, 64'd3);
    tick();
    chk("adr_high_locked", {63'd0, f_locked}, 64'd1);
    chk("adr_high_count", {32'd0, f_count}, 64'd6);

    F_stall = 1'b1;
    set_ret(1'b1, 64'd0);
    chk("stall_pc", f_pc, 64'd0);
    chk("stall_stat", {60'd0, f_stat}, 64'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_predPC", F_predPC, 64'h400);
    chk("stall_locked", {63'd0, f_locked}, 64'd1);
    chk("stall_count", {32'd0, f_count}, 64'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_predPC", F_predPC, 64'h0);
    chk("midrst_locked", {63'd0, f_locked}, 64'd0);
    chk("midrst_count", {32'd0, f_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
